// File: rtl/ifu_fetch_if.sv
// Fetch-side bus bundle: instruction memory req/gnt/rvalid and decode valid/ready.
// No logic of its own; latency is defined by the modules on either side.
// Backpressure via imem_gnt (request side) and dec_ready (decode side).
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;

  // Fetch unit drives requests and the decode payload.
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );

  // Memory/decode side answers the fetch unit.
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: holds PC, fetches one word per PC, hands it to decode.
// Latency: 3 cycles per instruction minimum (REQ -> WAIT -> HOLD).
// Backpressure: stalls in REQ without gnt, WAIT without rvalid, HOLD without dec_ready.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ifu_fetch_if.master      bus,
  output logic [31:0]      pc,
  input  logic [31:0]      npc,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [31:0] inst_q;
  logic        accept;
  logic        npc_aligned;

  // Outputs depend only on state, so accept can use the decoded inst_valid.
  assign accept      = (state == S_HOLD) && bus.dec_ready;
  assign npc_aligned = (npc[1:0] == 2'b00);

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  // Next-state logic; S_ERR only leaves via reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (bus.imem_gnt)    state_nxt = S_WAIT;
      S_WAIT:  if (bus.imem_rvalid) state_nxt = S_HOLD;
      S_HOLD:  if (accept)          state_nxt = npc_aligned ? S_REQ : S_ERR;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_REQ;
    endcase
  end

  // Output decode from state only; no path from imem_* or dec_ready.
  always_comb begin
    bus.imem_req   = 1'b0;
    bus.inst_valid = 1'b0;
    fetch_err      = 1'b0;
    case (state)
      S_REQ:   bus.imem_req   = 1'b1;
      S_HOLD:  bus.inst_valid = 1'b1;
      S_ERR:   fetch_err      = 1'b1;
      default: ;
    endcase
  end

  // Datapath: PC loads npc verbatim on aligned accept, word captured on rvalid in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inst_q      <= 32'h0;
      fetch_count <= '0;
    end else begin
      if ((state == S_WAIT) && bus.imem_rvalid) inst_q <= bus.imem_rdata;
      if (accept) begin
        fetch_count <= fetch_count + CNT_ONE;
        if (npc_aligned) pc <= npc;
      end
    end
  end

  assign bus.imem_addr = pc;
  assign bus.inst      = inst_q;
  assign bus.inst_pc   = pc;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc;
  logic [31:0] pc, pc4;
  logic        fetch_err, fetch_err4;
  logic [31:0] fetch_count;
  logic [3:0]  fetch_count4;

  int total = 0;
  int bad   = 0;

  ifu_fetch_if bus ();
  ifu_fetch_if bus4 ();

  // Second instance with a 4-bit counter sees identical stimulus.
  assign bus4.imem_gnt    = bus.imem_gnt;
  assign bus4.imem_rvalid = bus.imem_rvalid;
  assign bus4.imem_rdata  = bus.imem_rdata;
  assign bus4.dec_ready   = bus.dec_ready;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pc(pc), .npc(npc),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  ifu_fetch #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .pc(pc4), .npc(npc),
    .fetch_err(fetch_err4), .fetch_count(fetch_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        dr;
    logic [31:0] npc;
    logic        req;
    logic        iv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic dr, input logic [31:0] n);
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.dec_ready   = dr;
    npc             = n;
  endtask

  // Outputs are sampled at the falling edge, half a cycle from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One minimum-latency fetch starting in S_REQ.
  task automatic do_fetch(input logic [31:0] rd, input logic [31:0] n);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, rd,    1'b0, 32'h0); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, n);     tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // gnt rv rdata dr npc | req iv inst pc cnt
    v[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h3000,     32'd0};
    v[1]  = '{1'b0, 1'b1, 32'h2408_0005, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h3000,     32'd0};
    v[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3004,      1'b0, 1'b1, 32'h2408_0005, 32'h3000,     32'd0};
    v[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h3006,      1'b1, 1'b0, 32'h2408_0005, 32'h3004,     32'd1};
    v[4]  = '{1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0,         1'b0, 1'b0, 32'h2408_0005, 32'h3004,     32'd1};
    v[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3040,      1'b0, 1'b1, 32'h0000_0013, 32'h3004,     32'd1};
    v[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0013, 32'h3040,     32'd2};
    v[7]  = '{1'b0, 1'b1, 32'h0000_0011, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0013, 32'h3040,     32'd2};
    v[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0000, 1'b0, 1'b1, 32'h0000_0011, 32'h3040,     32'd2};
    v[9]  = '{1'b0, 1'b1, 32'hDEAD_0000, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0011, 32'h0040_0000, 32'd3};
    v[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0011, 32'h0040_0000, 32'd3};
    v[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0011, 32'h0040_0000, 32'd3};
    v[12] = '{1'b0, 1'b1, 32'h0000_0022, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0011, 32'h0040_0000, 32'd3};
    v[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h3006,      1'b0, 1'b1, 32'h0000_0022, 32'h0040_0000, 32'd3};
    v[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3000,      1'b0, 1'b1, 32'h0000_0022, 32'h0040_0000, 32'd3};
    v[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0022, 32'h3000,     32'd4};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_req", {31'h0, bus.imem_req}, 32'd1);
    chk("rst_iv", {31'h0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_err", {31'h0, fetch_err}, 32'd0);
    chk("rst_cnt", fetch_count, 32'd0);

    // Table: basic fetch, branch/jump targets, rvalid ignored in REQ, gated accept
    for (int i = 0; i < 16; i++) begin
      drive(v[i].gnt, v[i].rv, v[i].rdata, v[i].dr, v[i].npc);
      chk($sformatf("v%0d_req", i), {31'h0, bus.imem_req}, {31'h0, v[i].req});
      chk($sformatf("v%0d_iv", i), {31'h0, bus.inst_valid}, {31'h0, v[i].iv});
      chk($sformatf("v%0d_inst", i), bus.inst, v[i].inst);
      chk($sformatf("v%0d_addr", i), bus.imem_addr, v[i].pc);
      chk($sformatf("v%0d_ipc", i), bus.inst_pc, v[i].pc);
      chk($sformatf("v%0d_cnt", i), fetch_count, v[i].cnt);
      chk($sformatf("v%0d_err", i), {31'h0, fetch_err}, 32'd0);
      tick();
    end

    // Backpressure: gnt late 3, rvalid late 2, dec_ready low 4
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("bp_req", {31'h0, bus.imem_req}, 32'd1);
      chk("bp_addr", bus.imem_addr, 32'h3000);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("bp_addr_g", bus.imem_addr, 32'h3000);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("bp_wait_req", {31'h0, bus.imem_req}, 32'd0);
      chk("bp_wait_iv", {31'h0, bus.inst_valid}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'h5A5A_FFFF, 1'b0, 32'h3006);
      chk("bp_hold_iv", {31'h0, bus.inst_valid}, 32'd1);
      chk("bp_hold_inst", bus.inst, 32'hA5A5_0001);
      chk("bp_hold_pc", bus.inst_pc, 32'h3000);
      chk("bp_hold_cnt", fetch_count, 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3004);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("bp_cnt", fetch_count, 32'd1);
    chk("bp_pc", pc, 32'h3004);
    tick();
    chk("bp_cnt_once", fetch_count, 32'd1);

    // Misaligned target traps and sticks until reset
    do_reset();
    do_fetch(32'h0000_0033, 32'h3006);
    chk("mis_err", {31'h0, fetch_err}, 32'd1);
    chk("mis_pc", pc, 32'h3000);
    chk("mis_cnt", fetch_count, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h1111_1111, 1'b1, 32'h3008);
      chk("mis_req", {31'h0, bus.imem_req}, 32'd0);
      chk("mis_iv", {31'h0, bus.inst_valid}, 32'd0);
      chk("mis_sticky", {31'h0, fetch_err}, 32'd1);
      chk("mis_pc_hold", pc, 32'h3000);
      tick();
    end
    chk("mis_cnt_hold", fetch_count, 32'd1);
    do_reset();
    chk("mis_rst_err", {31'h0, fetch_err}, 32'd0);
    chk("mis_rst_pc", pc, 32'h3000);

    // Reset in S_WAIT; stale response after release is ignored
    do_fetch(32'h0000_0044, 32'h3010);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("mid_wait_req", {31'h0, bus.imem_req}, 32'd0);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    chk("mid_req", {31'h0, bus.imem_req}, 32'd1);
    chk("mid_addr", bus.imem_addr, 32'h3000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("mid_iv", {31'h0, bus.inst_valid}, 32'd0);
    chk("mid_req2", {31'h0, bus.imem_req}, 32'd1);
    chk("mid_inst", bus.inst, 32'h0);
    chk("mid_addr2", bus.imem_addr, 32'h3000);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int k = 0; k < 17; k++) begin
      do_fetch(32'h0000_0100 + k, 32'h3000 + 32'(4 * (k + 1)));
      chk($sformatf("wrap_cnt%0d", k), {28'h0, fetch_count4}, 32'((k + 1) % 16));
    end
    chk("wrap_cnt32", fetch_count, 32'd17);
    chk("wrap_pc", pc, 32'h3044);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of the next-PC logic. It holds the architectural PC and fetches the instruction word at that PC over a request/grant/response handshake with instruction memory. It presents the instruction to decode with a valid/ready handshake. When decode accepts an instruction, it loads the next PC computed downstream. Also provides a misaligned-target trap and a retired-fetch counter.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word aligned.
CNT_W, 32, width of fetch_count.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
pc  out  32  current PC; fed to next-PC logic
npc  in  32  next PC from next-PC logic; sampled only on decode accept
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, equals pc whenever imem_req=1
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
inst_valid  out  1  instruction held for decode
inst  out  32  held instruction word
inst_pc  out  32  PC of held instruction, equals pc
dec_ready  in  1  decode accepts instruction
fetch_err  out  1  sticky: misaligned npc accepted
fetch_count  out  CNT_W  number of instructions accepted by decode

Behaviour:
- Reset: rst_n sampled low at a clock edge gives pc=RESET_PC, state=S_REQ, inst=0, inst_valid=0, fetch_err=0, fetch_count=0. Applies from any state, including mid-request. A response to a pre-reset request is not consumed.
- FSM states: S_REQ, S_WAIT, S_HOLD, S_ERR.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 moves to S_WAIT.
  - imem_gnt=0 stays in S_REQ; address held stable.
  - imem_rvalid is ignored in this state.
- S_WAIT:
  - imem_req=0.
  - imem_rvalid=1 moves to S_HOLD with inst<=imem_rdata and inst_valid<=1.
  - Waits indefinitely otherwise.
  - At most one request is outstanding.
- S_HOLD:
  - inst_valid=1; inst and inst_pc held stable until accepted.
  - Accept is inst_valid & dec_ready.
  - On accept with npc[1:0]==0: pc<=npc, inst_valid<=0, fetch_count<=fetch_count+1, go to S_REQ.
  - On accept with npc[1:0]!=0: fetch_count increments, pc unchanged, inst_valid<=0, fetch_err<=1, go to S_ERR.
- S_ERR:
  - Terminal until reset.
  - imem_req=0, inst_valid=0, fetch_err=1.
- Minimum throughput: 3 cycles per instruction (gnt in the S_REQ cycle, rvalid in the following cycle, dec_ready high on the first HOLD cycle). imem_rvalid never arrives in the same cycle as its own grant.
- pc changes only on reset or on accept. npc is don't-care in all other cycles.
- fetch_count wraps modulo 2^CNT_W, from all ones to 0 with no flag.
- Arithmetic: no PC arithmetic in this block; npc is loaded verbatim.
- Outputs are registered or decoded from state only. There is no combinational path from imem_* or dec_ready to any output.

Test Plan:
1. Reset then fetch: rst_n low 2 cycles, release; gnt=1 on first req, rdata=32'h2408_0005 next cycle, dec_ready=1, npc=32'h3004 -> imem_addr=32'h3000, inst_valid high 1 cycle with inst=32'h2408_0005 and inst_pc=32'h3000, then pc=32'h3004, fetch_count=1, next imem_addr=32'h3004.
2. Backpressure: gnt delayed 3 cycles, rvalid delayed 2 cycles, dec_ready low 4 cycles -> imem_addr stable at 32'h3000 throughout; inst held constant; single increment of fetch_count on eventual accept.
3. Branch/jump target: accept with npc=32'h0000_3040, then 32'h0040_0000 -> consecutive imem_addr values 32'h3040, 32'h0040_0000; no intermediate address appears.
4. Misaligned target: accept with npc=32'h3006 -> fetch_err=1 the next cycle, pc stays 32'h3000, imem_req=0 forever; fetch_count=1; reset clears fetch_err=0 and pc=32'h3000.
5. Reset mid-operation: assert rst_n low in S_WAIT, drive rvalid with 32'hDEAD_BEEF in the cycle after release -> data ignored; inst_valid=0; state S_REQ with imem_addr=32'h3000.
6. Counter wrap: CNT_W=4, 17 accepted fetches -> fetch_count sequence ends 4'hF then 4'h0 then 4'h1.
